// File: rtl/line_fetcher.sv
// Scanline fetch engine: on each HSYNC rise, bursts one line of framebuffer words into the line buffer.
// Latency: first bus address one clock after the HSYNC rise; each acked word lands in the buffer in the ack cycle.
// Backpressure: the bus throttles via ack_i; cyc_o drops for one cycle after every BURST words.
//
// Ports: clk_i/reset_ni (sync, active-low); hsync_i/vsync_i/den_i CRTC timing;
//        fb_adr_i/line_len_i/stride_i/dbl_i frame geometry; cyc_o/adr_o/ack_i/err_i bus master;
//        s_we_o/s_adr_o line-buffer write port; busy_o/err_o/ovr_o status.
module line_fetcher #(
    parameter int AW    = 23,
    parameter int LW    = 9,
    parameter int BW    = 8,
    parameter int BURST = 16
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          hsync_i,
    input  logic          vsync_i,
    input  logic          den_i,
    input  logic [AW:1]   fb_adr_i,
    input  logic [LW-1:0] line_len_i,
    input  logic [AW:1]   stride_i,
    input  logic          dbl_i,
    input  logic          ack_i,
    input  logic          err_i,
    output logic          cyc_o,
    output logic [AW:1]   adr_o,
    output logic          s_we_o,
    output logic [BW:1]   s_adr_o,
    output logic          busy_o,
    output logic          err_o,
    output logic          ovr_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_GAP   = 2'd2,
        S_END   = 2'd3
    } state_t;

    localparam logic [LW-1:0] BURST_N = LW'(BURST);
    localparam logic [LW-1:0] ONE_W   = LW'(1);

    state_t        state;
    logic          hsync_q;
    logic          hs_rise;
    logic [AW:1]   line_base;
    logic          parity;
    logic [LW-1:0] cnt;
    logic [LW-1:0] bcnt;

    assign hs_rise = hsync_i & ~hsync_q;
    // Data is captured in the ack cycle; an erroring ack must not be written.
    assign s_we_o  = cyc_o & ack_i & ~err_i;
    assign busy_o  = (state != S_IDLE);

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state     <= S_IDLE;
            cyc_o     <= 1'b0;
            adr_o     <= '0;
            s_adr_o   <= '0;
            line_base <= '0;
            parity    <= 1'b0;
            cnt       <= '0;
            bcnt      <= '0;
            hsync_q   <= 1'b0;
            err_o     <= 1'b0;
            ovr_o     <= 1'b0;
        end else begin
            hsync_q <= hsync_i;
            if (vsync_i) begin
                // Frame restart wins over anything the FSM would otherwise do.
                state     <= S_IDLE;
                cyc_o     <= 1'b0;
                line_base <= fb_adr_i;
                adr_o     <= fb_adr_i;
                parity    <= 1'b0;
                err_o     <= 1'b0;
                ovr_o     <= 1'b0;
            end else begin
                // A new line request while one is still in flight is dropped and flagged.
                if (hs_rise && state != S_IDLE) begin
                    ovr_o <= 1'b1;
                end
                case (state)
                    S_IDLE: begin
                        if (hs_rise && den_i && line_len_i != '0) begin
                            state   <= S_FETCH;
                            cyc_o   <= 1'b1;
                            cnt     <= line_len_i;
                            adr_o   <= line_base;
                            s_adr_o <= '0;
                            bcnt    <= '0;
                        end
                    end
                    S_FETCH: begin
                        // cyc_o is always high here, so err_i alone qualifies the error.
                        if (err_i) begin
                            err_o <= 1'b1;
                            cyc_o <= 1'b0;
                            state <= S_END;
                        end else if (ack_i) begin
                            adr_o   <= adr_o + AW'(1);
                            s_adr_o <= s_adr_o + BW'(1);
                            cnt     <= cnt - ONE_W;
                            bcnt    <= bcnt + ONE_W;
                            // Line completion takes priority over the burst break.
                            if (cnt == ONE_W) begin
                                state <= S_END;
                                cyc_o <= 1'b0;
                            end else if (bcnt + ONE_W == BURST_N) begin
                                state <= S_GAP;
                                cyc_o <= 1'b0;
                            end
                        end
                    end
                    S_GAP: begin
                        state <= S_FETCH;
                        cyc_o <= 1'b1;
                        bcnt  <= '0;
                    end
                    S_END: begin
                        state <= S_IDLE;
                        // In doubling mode the first pass of a source line keeps the base.
                        if (dbl_i && !parity) begin
                            parity <= 1'b1;
                        end else begin
                            line_base <= line_base + AW'(line_len_i) + stride_i;
                            parity    <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_line_fetcher.sv
module tb_line_fetcher;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        hsync, vsync, den, dbl, ack, err;
    logic [23:1] fb_adr, stride;
    logic [8:0]  line_len;

    logic        a_cyc, a_we, a_busy, a_err, a_ovr;
    logic [23:1] a_adr;
    logic [8:1]  a_sadr;
    logic        b_cyc, b_we, b_busy, b_err, b_ovr;
    logic [23:1] b_adr;
    logic [8:1]  b_sadr;

    int checks = 0;
    int errors = 0;
    int writes;
    logic [11:0] pat;

    always #5 clk = ~clk;

    line_fetcher dut (
        .clk_i(clk), .reset_ni(reset_ni), .hsync_i(hsync), .vsync_i(vsync), .den_i(den),
        .fb_adr_i(fb_adr), .line_len_i(line_len), .stride_i(stride), .dbl_i(dbl),
        .ack_i(ack), .err_i(err), .cyc_o(a_cyc), .adr_o(a_adr), .s_we_o(a_we),
        .s_adr_o(a_sadr), .busy_o(a_busy), .err_o(a_err), .ovr_o(a_ovr)
    );

    line_fetcher #(.BURST(4)) dut4 (
        .clk_i(clk), .reset_ni(reset_ni), .hsync_i(hsync), .vsync_i(vsync), .den_i(den),
        .fb_adr_i(fb_adr), .line_len_i(line_len), .stride_i(stride), .dbl_i(dbl),
        .ack_i(ack), .err_i(err), .cyc_o(b_cyc), .adr_o(b_adr), .s_we_o(b_we),
        .s_adr_o(b_sadr), .busy_o(b_busy), .err_o(b_err), .ovr_o(b_ovr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hs_pulse();
        hsync = 1'b1;
        tick();
        hsync = 1'b0;
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    // Start a line, check its first address on both instances, then let it drain.
    task automatic do_line(input string tag, input logic [23:1] exp_adr);
        hs_pulse();
        check({tag, "_cyc"}, 32'(a_cyc), 32'd1);
        check({tag, "_adr"}, 32'(a_adr), 32'(exp_adr));
        check({tag, "_adr4"}, 32'(b_adr), 32'(exp_adr));
        repeat (14) tick();
        check({tag, "_idle"}, 32'(a_busy | b_busy), 32'd0);
    endtask

    initial begin
        reset_ni = 1'b0; hsync = 1'b0; vsync = 1'b0; den = 1'b1; dbl = 1'b0;
        ack = 1'b0; err = 1'b0; fb_adr = '0; stride = '0; line_len = '0;
        tick(); tick();
        check("rst_cyc",  32'(a_cyc),  32'd0);
        check("rst_adr",  32'(a_adr),  32'd0);
        check("rst_sadr", 32'(a_sadr), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_err",  32'(a_err),  32'd0);
        check("rst_ovr",  32'(a_ovr),  32'd0);
        reset_ni = 1'b1;

        // Frame start at 0x1000.
        fb_adr = 23'h1000;
        vs_pulse();
        check("vs_adr", 32'(a_adr), 32'h1000);

        // Zero-length line and den low must not start a fetch.
        ack = 1'b1;
        hs_pulse();
        check("len0_idle", 32'(a_busy), 32'd0);
        tick();
        line_len = 9'd4; den = 1'b0;
        hs_pulse();
        check("den0_idle", 32'(a_busy), 32'd0);
        tick();
        den = 1'b1;

        // Four-word line with ack tied high.
        hs_pulse();
        for (int i = 0; i < 4; i++) begin
            check("l4_cyc",  32'(a_cyc),  32'd1);
            check("l4_adr",  32'(a_adr),  32'h1000 + 32'(i));
            check("l4_sadr", 32'(a_sadr), 32'(i));
            check("l4_we",   32'(a_we),   32'd1);
            tick();
        end
        check("l4_end_cyc",  32'(a_cyc),  32'd0);
        check("l4_end_busy", 32'(a_busy), 32'd1);
        tick();
        check("l4_idle", 32'(a_busy), 32'd0);
        do_line("l4b", 23'h1004);

        // Ten-word line: BURST=4 instance must break into 4/4/2 with one-cycle gaps.
        line_len = 9'd10;
        hs_pulse();
        check("l10_adr", 32'(b_adr), 32'h1008);
        pat = 12'b1111_0111_1011;
        writes = 0;
        for (int i = 0; i < 12; i++) begin
            check("l10_cyc4", 32'(b_cyc), 32'(pat[11 - i]));
            if (i < 10) check("l10_cyc16", 32'(a_cyc), 32'd1);
            if (b_we) writes++;
            tick();
        end
        check("l10_writes", 32'(writes), 32'd10);
        check("l10_sadr4",  32'(b_sadr), 32'd10);
        check("l10_end",    32'(b_cyc),  32'd0);
        tick(); tick();

        // Line doubling: two passes per source line, then advance by len+stride.
        fb_adr = 23'h2000;
        vs_pulse();
        dbl = 1'b1; line_len = 9'd8; stride = 23'd8;
        do_line("dbl1", 23'h2000);
        do_line("dbl2", 23'h2000);
        do_line("dbl3", 23'h2010);

        // Bus error on the third ack of a six-word line.
        dbl = 1'b0; stride = '0; line_len = 9'd6; fb_adr = 23'h3000;
        vs_pulse();
        hs_pulse();
        check("err_we1", 32'(a_we), 32'd1);
        tick();
        check("err_we2", 32'(a_we), 32'd1);
        tick();
        err = 1'b1;
        #1;
        check("err_we_sup", 32'(a_we), 32'd0);
        tick();
        err = 1'b0;
        check("err_flag", 32'(a_err),  32'd1);
        check("err_cyc",  32'(a_cyc),  32'd0);
        check("err_sadr", 32'(a_sadr), 32'd2);
        tick();
        check("err_idle", 32'(a_busy), 32'd0);
        vs_pulse();
        check("err_clr", 32'(a_err), 32'd0);

        // Overrun: second hsync rise with three words left.
        hs_pulse();
        tick(); tick(); tick();
        check("ovr_sadr3", 32'(a_sadr), 32'd3);
        hs_pulse();
        check("ovr_flag", 32'(a_ovr), 32'd1);
        check("ovr_cyc",  32'(a_cyc), 32'd1);
        tick(); tick();
        check("ovr_sadr6", 32'(a_sadr), 32'd6);
        check("ovr_done",  32'(a_cyc),  32'd0);
        tick();

        // vsync mid-line aborts and reloads the frame base.
        fb_adr = 23'h4000;
        hs_pulse();
        check("vsm_adr0", 32'(a_adr), 32'h3006);
        tick(); tick();
        vs_pulse();
        check("vsm_cyc",  32'(a_cyc),  32'd0);
        check("vsm_adr",  32'(a_adr),  32'h4000);
        check("vsm_ovr",  32'(a_ovr),  32'd0);
        check("vsm_busy", 32'(a_busy), 32'd0);

        // Reset in the middle of a fetch.
        hs_pulse();
        check("rmid_cyc0", 32'(a_cyc), 32'd1);
        tick();
        reset_ni = 1'b0;
        tick();
        check("rmid_cyc",  32'(a_cyc),  32'd0);
        check("rmid_adr",  32'(a_adr),  32'd0);
        check("rmid_busy", 32'(a_busy), 32'd0);
        check("rmid_sadr", 32'(a_sadr), 32'd0);
        reset_ni = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
